// File: rtl/io_pkg.sv
// Shared IO-module definitions: decoder FSM states, token layout and the
// default geometry the row DMA is built for.
package io_pkg;

  localparam int DEF_ROW_SIZE = 16;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_NUM_ROWS = 16;

  // Run bit sits just above the run-length field of a token.
  localparam int RUN_BIT_POS  = DEF_CNT_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    ROW_OUT = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/rle_row_decompressor_if.sv
// Token input and row output handshakes between the token source, the RLE
// decoder and the row DMA.
interface rle_row_decompressor_if #(
  parameter int ROW_SIZE = io_pkg::DEF_ROW_SIZE,
  parameter int CNT_W    = io_pkg::DEF_CNT_W
);
  // Valid/ready: a token transfers at a posedge where in_valid && in_ready;
  // the source holds in_data stable while in_valid is high and not accepted.
  // A row transfers at a posedge where row_valid && row_ack; row_out is held
  // unchanged while row_valid is high.
  logic                in_valid;
  logic [CNT_W:0]      in_data;
  logic                in_ready;
  logic [ROW_SIZE-1:0] row_out;
  logic                row_valid;
  logic                row_ack;

  modport master (
    output in_valid, in_data, row_ack,
    input  in_ready, row_out, row_valid
  );

  modport slave (
    input  in_valid, in_data, row_ack,
    output in_ready, row_out, row_valid
  );
endinterface

// File: rtl/rle_run_filler.sv
// Writes as much of the current run as fits into the row being assembled,
// starting at fill_ptr; k is the number of bits written this cycle.
module rle_run_filler #(
  parameter  int ROW_SIZE = 16,
  parameter  int CNT_W    = 8,
  localparam int PW       = $clog2(ROW_SIZE + 1)
) (
  input  logic [PW-1:0]       fill_ptr,
  input  logic [CNT_W-1:0]    run_rem,
  input  logic                run_bit,
  input  logic [ROW_SIZE-1:0] row_buf,
  output logic [PW-1:0]       k,
  output logic [ROW_SIZE-1:0] row_buf_nxt
);

  // Wide enough for both operands plus headroom for fill_ptr + k.
  localparam int XW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  logic [XW-1:0] space_x;
  logic [XW-1:0] rem_x;
  logic [XW-1:0] k_x;
  logic [XW-1:0] end_x;

  always_comb begin
    space_x     = XW'(ROW_SIZE) - XW'(fill_ptr);
    rem_x       = XW'(run_rem);
    k_x         = (rem_x < space_x) ? rem_x : space_x;
    k           = PW'(k_x);
    end_x       = XW'(fill_ptr) + k_x;
    row_buf_nxt = row_buf;
    for (int i = 0; i < ROW_SIZE; i++) begin
      if ((XW'(i) >= XW'(fill_ptr)) && (XW'(i) < end_x)) begin
        row_buf_nxt[i] = run_bit;
      end
    end
  end

endmodule

// File: rtl/rle_row_decompressor.sv
// Run-length decoder feeding the row DMA: rebuilds ROW_SIZE-bit rows from
// {bit, length} tokens, holds each row until acked, and counts rows per frame.
module rle_row_decompressor
  import io_pkg::*;
#(
  parameter int ROW_SIZE = DEF_ROW_SIZE,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  rle_row_decompressor_if.slave        bus,
  output logic                         frame_done,
  output logic                         overrun_err,
  output logic                         busy,
  output state_e                       dbg_state
);

  localparam int PW = $clog2(ROW_SIZE + 1);
  localparam int RW = $clog2(NUM_ROWS + 1);

  state_e              state_q, state_d;
  logic [ROW_SIZE-1:0] row_buf_q, row_buf_d;
  logic [PW-1:0]       fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0]    run_rem_q, run_rem_d;
  logic                run_bit_q, run_bit_d;
  logic [RW-1:0]       row_cnt_q, row_cnt_d;
  logic                overrun_q, overrun_d;
  logic                row_valid_q, frame_done_q, busy_q;

  logic [PW-1:0]       k;
  logic [ROW_SIZE-1:0] row_buf_fill;
  logic                in_ready;

  rle_run_filler #(
    .ROW_SIZE (ROW_SIZE),
    .CNT_W    (CNT_W)
  ) u_filler (
    .fill_ptr    (fill_ptr_q),
    .run_rem     (run_rem_q),
    .run_bit     (run_bit_q),
    .row_buf     (row_buf_q),
    .k           (k),
    .row_buf_nxt (row_buf_fill)
  );

  // A token is only taken once the previous run is fully written.
  assign in_ready = (state_q == FILL) && (run_rem_q == '0);

  always_comb begin
    state_d    = state_q;
    row_buf_d  = row_buf_q;
    fill_ptr_d = fill_ptr_q;
    run_rem_d  = run_rem_q;
    run_bit_d  = run_bit_q;
    row_cnt_d  = row_cnt_q;
    overrun_d  = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          overrun_d  = 1'b0;
          row_cnt_d  = '0;
          row_buf_d  = '0;
          fill_ptr_d = '0;
          run_rem_d  = '0;
        end
      end
      FILL: begin
        if (run_rem_q == '0) begin
          if (bus.in_valid) begin
            run_rem_d = bus.in_data[CNT_W-1:0];
            run_bit_d = bus.in_data[CNT_W];
          end
        end else begin
          row_buf_d  = row_buf_fill;
          fill_ptr_d = fill_ptr_q + k;
          run_rem_d  = run_rem_q - CNT_W'(k);
          if (fill_ptr_d == PW'(ROW_SIZE)) state_d = ROW_OUT;
        end
      end
      ROW_OUT: begin
        if (bus.row_ack) begin
          row_buf_d  = '0;
          fill_ptr_d = '0;
          row_cnt_d  = row_cnt_q + 1'b1;
          if (row_cnt_q == RW'(NUM_ROWS - 1)) begin
            state_d = DONE;
            // Leftover run bits at frame end mean the stream was malformed.
            if (run_rem_q != '0) begin
              overrun_d = 1'b1;
              run_rem_d = '0;
            end
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_buf_q    <= '0;
      fill_ptr_q   <= '0;
      run_rem_q    <= '0;
      run_bit_q    <= 1'b0;
      row_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_buf_q    <= row_buf_d;
      fill_ptr_q   <= fill_ptr_d;
      run_rem_q    <= run_rem_d;
      run_bit_q    <= run_bit_d;
      row_cnt_q    <= row_cnt_d;
      overrun_q    <= overrun_d;
      row_valid_q  <= (state_d == ROW_OUT);
      frame_done_q <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.row_out   = row_buf_q;
  assign bus.row_valid = row_valid_q;
  assign frame_done    = frame_done_q;
  assign overrun_err   = overrun_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rle_row_decompressor.sv
// Directed bench for rle_row_decompressor with ROW_SIZE=16, CNT_W=8,
// NUM_ROWS=2; expected rows are hand-computed from the token streams.
module tb_rle_row_decompressor;
  import io_pkg::*;

  localparam int ROW_SIZE = 16;
  localparam int CNT_W    = 8;
  localparam int NUM_ROWS = 2;
  localparam int BUDGET   = 100;

  logic   clk;
  logic   rst;
  logic   start;
  logic   frame_done;
  logic   overrun_err;
  logic   busy;
  state_e dbg_state;

  int n_cmp;
  int n_fail;

  rle_row_decompressor_if #(.ROW_SIZE(ROW_SIZE), .CNT_W(CNT_W)) bus ();

  rle_row_decompressor #(
    .ROW_SIZE (ROW_SIZE),
    .CNT_W    (CNT_W),
    .NUM_ROWS (NUM_ROWS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus.slave),
    .frame_done  (frame_done),
    .overrun_err (overrun_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_token(input logic v, input logic [CNT_W-1:0] len, input string name);
    logic taken;
    logic rdy;
    taken = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = {v, len};
    for (int c = 0; c < BUDGET; c++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        taken = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (!taken) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: token not accepted within %0d cycles (actual in_ready=%0b, required 1)",
               name, BUDGET, bus.in_ready);
    end
  endtask

  task automatic wait_row(input logic [ROW_SIZE-1:0] exp, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (bus.row_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: row_valid never rose (actual 0, required 1)", name);
    end else if (bus.row_out !== exp) begin
      n_fail++;
      $display("FAIL %s: row_out actual 0x%04h required 0x%04h", name, bus.row_out, exp);
    end
  endtask

  // Leaves the bench at the negedge right after the acking posedge.
  task automatic ack_row();
    @(negedge clk);
    bus.row_ack = 1'b1;
    @(negedge clk);
    bus.row_ack = 1'b0;
  endtask

  task automatic check_frame_end(input logic exp_ovr, input string name);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: frame_done actual %0b required 1", name, frame_done);
    end
    n_cmp++;
    if (overrun_err !== exp_ovr) begin
      n_fail++;
      $display("FAIL %s_ovr: overrun_err actual %0b required %0b", name, overrun_err, exp_ovr);
    end
    @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: frame_done/busy actual %0b/%0b required 0/0", name, frame_done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({bus.row_out, bus.row_valid, bus.in_ready, frame_done, overrun_err, busy} !== '0 ||
        dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset: row_out=0x%04h rv=%0b rdy=%0b fd=%0b ovr=%0b busy=%0b state=%0d required all 0",
               bus.row_out, bus.row_valid, bus.in_ready, frame_done, overrun_err, busy, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_row();
    do_start();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy actual %0b required 1", busy);
    end
    send_token(1'b0, 8'd4, "t1_a");
    send_token(1'b1, 8'd8, "t1_b");
    send_token(1'b0, 8'd4, "t1_c");
    wait_row(16'h0FF0, "t1_row0");
    ack_row();
    n_cmp++;
    if (bus.row_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_after_ack: row_valid/in_ready actual %0b/%0b required 0/1",
               bus.row_valid, bus.in_ready);
    end
    send_token(1'b0, 8'd16, "t1_d");
    wait_row(16'h0000, "t1_row1");
    ack_row();
    check_frame_end(1'b0, "t1_end");
  endtask

  task automatic test_span_rows();
    do_start();
    send_token(1'b1, 8'd20, "t2_a");
    wait_row(16'hFFFF, "t2_row0");
    ack_row();
    send_token(1'b0, 8'd12, "t2_b");
    wait_row(16'h000F, "t2_row1");
    ack_row();
    check_frame_end(1'b0, "t2_end");
  endtask

  task automatic test_backpressure();
    do_start();
    send_token(1'b1, 8'd8, "t3_a");
    send_token(1'b0, 8'd8, "t3_b");
    wait_row(16'h00FF, "t3_row0");
    // A token waits on the bus while the DMA stalls; it must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = {1'b1, 8'd16};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.row_out !== 16'h00FF || bus.row_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL t3_hold%0d: row_out=0x%04h rv=%0b rdy=%0b required 0x00ff/1/0",
                 c, bus.row_out, bus.row_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    ack_row();
    send_token(1'b0, 8'd16, "t3_c");
    wait_row(16'h0000, "t3_row1");
    ack_row();
    check_frame_end(1'b0, "t3_end");
  endtask

  task automatic test_zero_token();
    do_start();
    send_token(1'b1, 8'd0, "t4_zero");
    send_token(1'b1, 8'd16, "t4_a");
    wait_row(16'hFFFF, "t4_row0");
    ack_row();
    send_token(1'b0, 8'd16, "t4_b");
    wait_row(16'h0000, "t4_row1");
    ack_row();
    check_frame_end(1'b0, "t4_end");
  endtask

  task automatic test_overrun();
    do_start();
    send_token(1'b1, 8'd16, "t5_a");
    wait_row(16'hFFFF, "t5_row0");
    ack_row();
    send_token(1'b0, 8'd20, "t5_b");
    wait_row(16'h0000, "t5_row1");
    ack_row();
    check_frame_end(1'b1, "t5_end");
    n_cmp++;
    if (overrun_err !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_sticky: overrun_err actual %0b required 1", overrun_err);
    end
    do_start();
    n_cmp++;
    if (overrun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_clear: overrun_err actual %0b required 0", overrun_err);
    end
  endtask

  task automatic test_mid_reset();
    send_token(1'b1, 8'd7, "t6_a");
    @(negedge clk);
    n_cmp++;
    if (bus.row_out !== 16'h007F) begin
      n_fail++;
      $display("FAIL t6_partial: row_out actual 0x%04h required 0x007f", bus.row_out);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.row_out, bus.row_valid, bus.in_ready, frame_done, overrun_err, busy} !== '0 ||
        dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL t6_reset: row_out=0x%04h rv=%0b rdy=%0b fd=%0b ovr=%0b busy=%0b required all 0",
               bus.row_out, bus.row_valid, bus.in_ready, frame_done, overrun_err, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    do_start();
    send_token(1'b1, 8'd16, "t6_b");
    wait_row(16'hFFFF, "t6_row0");
    ack_row();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.row_ack  = 1'b0;
    test_reset();
    test_basic_row();
    test_span_rows();
    test_backpressure();
    test_zero_token();
    test_overrun();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
